// File: rtl/motor_drive.sv
// Dual H-bridge drive stage: takes the command FSM's motor_stat/duty and
// produces per-wheel IN pairs plus PWM enables, with dead time inserted on
// every command change and an optional soft-start duty ramp.
// Optional feature macro: MOTOR_DRIVE_SOFT_START_EN (defined = ramp duty up by
// RAMP_STEP per PWM period; undefined = apply the target duty directly).
module motor_drive #(
  parameter int unsigned PRESCALE    = 25,
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned RAMP_STEP   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] motor_stat,
  input  logic [6:0] duty,
  output logic [1:0] l_in,
  output logic [1:0] r_in,
  output logic       l_en,
  output logic       r_en,
  output logic [6:0] cur_duty,
  output logic       dead,
  output logic       fault
);

  localparam int unsigned    PreW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(PRESCALE - 1);
  localparam logic [19:0]    DeadLoad = 20'(DEAD_CYCLES - 1);

`ifdef MOTOR_DRIVE_SOFT_START_EN
  localparam bit          SoftStart = 1'b1;
  localparam logic [7:0]  RampInc   = 8'(RAMP_STEP);
`else
  localparam bit          SoftStart = 1'b0;
`endif

  // Reject out-of-range configurations at elaboration.
  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 1048575) begin : g_bad_dead
    $error("motor_drive: DEAD_CYCLES out of range");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 100) begin : g_bad_ramp
    $error("motor_drive: RAMP_STEP out of range");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("motor_drive: PRESCALE must be at least 1");
  end

  typedef enum logic [1:0] {StCoast, StRun, StBrake, StDead} state_e;

  state_e          state_q;
  logic [2:0]      cmd_q;
  logic [6:0]      tgt_q;
  logic [2:0]      held_q;
  logic [19:0]     dead_cnt_q;
  logic [PreW-1:0] pre_cnt_q;
  logic [6:0]      pwm_cnt_q;

  logic       change;
  logic       invalid;
  logic       step_tick;
  logic       period_end;
  logic       pwm_on;
  logic [2:0] exit_cmd;
  logic [6:0] duty_next;

  // Bridge pattern {l_in, r_in} for a command; invalid codes fall back to brake.
  function automatic logic [3:0] cmd_dir(input logic [2:0] cmd);
    unique case (cmd)
      3'b000:  cmd_dir = 4'b0000;
      3'b001:  cmd_dir = 4'b1010;
      3'b010:  cmd_dir = 4'b0110;
      3'b011:  cmd_dir = 4'b1111;
      3'b100:  cmd_dir = 4'b1001;
      3'b101:  cmd_dir = 4'b0101;
      default: cmd_dir = 4'b1111;
    endcase
  endfunction

  function automatic state_e cmd_state(input logic [2:0] cmd);
    unique case (cmd)
      3'b000:                 cmd_state = StCoast;
      3'b011, 3'b110, 3'b111: cmd_state = StBrake;
      default:                cmd_state = StRun;
    endcase
  endfunction

  // Register the raw command and the clamped target duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= 3'b000;
      tgt_q <= 7'd0;
    end else begin
      cmd_q <= motor_stat;
      tgt_q <= (duty > 7'd100) ? 7'd100 : duty;
    end
  end

  // Change detection, PWM timing and period-boundary duty selection.
  always_comb begin
    change     = (cmd_q != held_q);
    invalid    = cmd_q[2] & cmd_q[1];
    step_tick  = (pre_cnt_q == PreMax);
    period_end = step_tick && (pwm_cnt_q == 7'd99);
    pwm_on     = (pwm_cnt_q < cur_duty);
    // A change arriving on the final dead cycle is honoured on exit.
    exit_cmd   = change ? cmd_q : held_q;
`ifdef MOTOR_DRIVE_SOFT_START_EN
    duty_next  = tgt_q;
    if (tgt_q > cur_duty) begin
      // 8-bit add so the sum cannot wrap before clamping to target.
      if (({1'b0, cur_duty} + RampInc) > {1'b0, tgt_q}) begin
        duty_next = tgt_q;
      end else begin
        duty_next = cur_duty + RampInc[6:0];
      end
    end
`else
    duty_next  = tgt_q;
`endif
  end

  // Main FSM: dead-time sequencing, PWM counters and registered bridge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCoast;
      held_q     <= 3'b000;
      dead_cnt_q <= 20'd0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= 7'd0;
      cur_duty   <= 7'd0;
      l_in       <= 2'b00;
      r_in       <= 2'b00;
      dead       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (invalid) begin
        fault <= 1'b1;
      end
      if (change) begin
        held_q <= cmd_q;
      end
      if (state_q == StDead) begin
        if (dead_cnt_q == 20'd0) begin
          state_q      <= cmd_state(exit_cmd);
          {l_in, r_in} <= cmd_dir(exit_cmd);
          dead         <= 1'b0;
          pre_cnt_q    <= '0;
          pwm_cnt_q    <= 7'd0;
          cur_duty     <= (cmd_state(exit_cmd) == StRun && !SoftStart) ? tgt_q : 7'd0;
        end else begin
          dead_cnt_q <= dead_cnt_q - 20'd1;
        end
      end else if (change) begin
        state_q    <= StDead;
        dead_cnt_q <= DeadLoad;
        dead       <= 1'b1;
        l_in       <= 2'b00;
        r_in       <= 2'b00;
        cur_duty   <= 7'd0;
        pre_cnt_q  <= '0;
        pwm_cnt_q  <= 7'd0;
      end else if (state_q == StRun) begin
        pre_cnt_q <= step_tick ? '0 : pre_cnt_q + 1'b1;
        if (step_tick) begin
          pwm_cnt_q <= period_end ? 7'd0 : pwm_cnt_q + 7'd1;
        end
        // Duty only moves on the period boundary so a period is never cut short.
        if (period_end) begin
          cur_duty <= duty_next;
        end
      end
    end
  end

  // Enables: PWM while running, full on while braking, off otherwise.
  always_comb begin
    l_en = (state_q == StBrake) | ((state_q == StRun) & pwm_on);
    r_en = l_en;
  end

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with PRESCALE=1, DEAD_CYCLES=8, RAMP_STEP=25.
// Expected duty values follow the build: ramped when MOTOR_DRIVE_SOFT_START_EN
// is defined, direct otherwise.
module tb_motor_drive;

`ifdef MOTOR_DRIVE_SOFT_START_EN
  localparam bit Ramp = 1'b1;
`else
  localparam bit Ramp = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] motor_stat;
  logic [6:0] duty;
  logic [1:0] l_in;
  logic [1:0] r_in;
  logic       l_en;
  logic       r_en;
  logic [6:0] cur_duty;
  logic       dead;
  logic       fault;

  int total = 0;
  int bad   = 0;

  motor_drive #(
    .PRESCALE    (1),
    .DEAD_CYCLES (8),
    .RAMP_STEP   (25)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .motor_stat (motor_stat),
    .duty       (duty),
    .l_in       (l_in),
    .r_in       (r_in),
    .l_en       (l_en),
    .r_en       (r_en),
    .cur_duty   (cur_duty),
    .dead       (dead),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for DEAD, then count its length; optionally change the
  // command once DEAD has been seen for sw_at cycles.
  task automatic run_dead(input int sw_at, input logic [2:0] sw_cmd,
                          output int len, output bit quiet);
    len   = 0;
    quiet = 1'b1;
    for (int i = 0; i < 20 && dead !== 1'b1; i++) @(negedge clk);
    while (dead === 1'b1 && len < 100) begin
      len++;
      if (l_in !== 2'b00 || r_in !== 2'b00 || l_en !== 1'b0 || r_en !== 1'b0 ||
          cur_duty !== 7'd0) quiet = 1'b0;
      if (len == sw_at) motor_stat = sw_cmd;
      @(negedge clk);
    end
  endtask

  int  len;
  bit  quiet;
  int  cnt;
  bit  ok;

  initial begin
    rst_n      = 1'b0;
    motor_stat = 3'b000;
    duty       = 7'd0;
    tick(2);
    check("rst_l_in", l_in, 2'b00);
    check("rst_r_in", r_in, 2'b00);
    check("rst_en", {l_en, r_en}, 2'b00);
    check("rst_duty", cur_duty, 0);
    check("rst_dead_fault", {dead, fault}, 2'b00);
    rst_n = 1'b1;
    tick(3);
    check("coast_idle", {l_in, r_in, dead}, 5'b0);

    // Forward at 60 from coast.
    motor_stat = 3'b001;
    duty       = 7'd60;
    run_dead(0, 3'b000, len, quiet);
    check("fwd_dead_len", len, 8);
    check("fwd_dead_quiet", quiet, 1);
    check("fwd_dir", {l_in, r_in}, 4'b1010);
    check("fwd_duty0", cur_duty, Ramp ? 0 : 60);
    tick(100);
    check("fwd_duty1", cur_duty, Ramp ? 25 : 60);
    tick(100);
    check("fwd_duty2", cur_duty, Ramp ? 50 : 60);
    tick(100);
    check("fwd_duty3", cur_duty, 60);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (l_en === 1'b1) cnt++;
      @(negedge clk);
    end
    check("fwd_en_count", cnt, 60);

    // Reverse: dead time, then restart from zero duty.
    motor_stat = 3'b101;
    run_dead(0, 3'b000, len, quiet);
    check("back_dead_len", len, 8);
    check("back_dead_quiet", quiet, 1);
    check("back_dir", {l_in, r_in}, 4'b0101);
    check("back_duty0", cur_duty, Ramp ? 0 : 60);
    tick(100);
    check("back_duty1", cur_duty, Ramp ? 25 : 60);
    tick(200);
    check("back_duty3", cur_duty, 60);

    // Duty drop with the command held: no dead time, applied at period end.
    duty = 7'd20;
    ok   = 1'b1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (dead !== 1'b0 || cur_duty !== 7'd60) ok = 1'b0;
    end
    check("drop_hold_mid_period", ok, 1);
    tick(1);
    check("drop_applied", cur_duty, 20);
    check("drop_dir", {l_in, r_in, dead}, 5'b01010);

    // Over-range duty clamps to 100: constant-high enable.
    motor_stat = 3'b001;
    duty       = 7'd120;
    run_dead(0, 3'b000, len, quiet);
    check("clamp_dead_len", len, 8);
    check("clamp_dir", {l_in, r_in}, 4'b1010);
    tick(400);
    check("clamp_duty", cur_duty, 100);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (l_en === 1'b1 && r_en === 1'b1) cnt++;
      @(negedge clk);
    end
    check("clamp_en_count", cnt, 100);

    // Invalid command: sticky fault, brake after dead time.
    motor_stat = 3'b111;
    run_dead(0, 3'b000, len, quiet);
    check("inv_dead_len", len, 8);
    check("inv_fault", fault, 1);
    check("inv_brake_in", {l_in, r_in}, 4'b1111);
    check("inv_brake_en", {l_en, r_en}, 2'b11);
    check("inv_brake_duty", cur_duty, 0);
    motor_stat = 3'b000;
    run_dead(0, 3'b000, len, quiet);
    check("coast_dead_len", len, 8);
    check("coast_out", {l_in, r_in, l_en, r_en}, 6'b0);
    check("coast_fault_sticky", fault, 1);

    // Multiple changes inside DEAD, then reset with three dead cycles left.
    motor_stat = 3'b001;
    duty       = 7'd40;
    for (int i = 0; i < 20 && dead !== 1'b1; i++) @(negedge clk);
    check("mid_dead_start", dead, 1);
    motor_stat = 3'b100;
    tick(1);
    motor_stat = 3'b010;
    tick(3);
    check("mid_dead_still", dead, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {l_in, r_in, l_en, r_en, dead, fault}, 8'b0);
    check("mid_rst_duty", cur_duty, 0);
    motor_stat = 3'b000;
    duty       = 7'd0;
    tick(2);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dead !== 1'b0 || l_in !== 2'b00 || r_in !== 2'b00 || l_en !== 1'b0) ok = 1'b0;
    end
    check("post_rst_coast", ok, 1);

    // Change during DEAD only relatches the command; length stays 8.
    motor_stat = 3'b001;
    duty       = 7'd40;
    run_dead(2, 3'b100, len, quiet);
    check("relatch_dead_len", len, 8);
    check("relatch_dir", {l_in, r_in}, 4'b1001);
    check("relatch_duty0", cur_duty, Ramp ? 0 : 40);
    tick(100);
    check("relatch_duty1", cur_duty, Ramp ? 25 : 40);
    tick(100);
    check("relatch_duty2", cur_duty, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Downstream stage of the main command FSM: consumes its 3-bit MOTOR_STAT and 7-bit DUTY outputs and drives a dual H-bridge (left and right wheels), one IN pair plus one EN/PWM line per wheel.
- Generates a PWM period of 100 steps.
- Inserts dead time on every command change so the bridge is never switched directly between directions.
- Ramps duty to limit inrush current.

Parameters:
- PRESCALE, 25: CLK cycles per PWM step. At 50 MHz, 100 steps per period gives 20 kHz PWM.
- DEAD_CYCLES, 50000: CLK cycles both bridges are held off on a command change (1 ms at 50 MHz). Legal range 1 to 2^20-1.
- RAMP_STEP, 5: duty percent added per PWM period while ramping up. Legal range 1 to 100.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- MOTOR_STAT  in  3  command: 000 coast, 001 fwd, 010 left, 011 brake, 100 right, 101 back, 110/111 invalid.
- DUTY  in  7  target duty in percent; values above 100 are clamped to 100.
- L_IN  out  2  left bridge inputs: 10 fwd, 01 rev, 11 brake, 00 off.
- R_IN  out  2  right bridge inputs, same encoding.
- L_EN  out  1  left bridge enable/PWM.
- R_EN  out  1  right bridge enable/PWM.
- CUR_DUTY  out  7  duty currently applied, 0–100.
- DEAD  out  1  high while in the DEAD state.
- FAULT  out  1  sticky; set on an invalid command, cleared only by reset.

Behaviour:
- Reset: L_IN = R_IN = 00, L_EN = R_EN = 0, CUR_DUTY = 0, DEAD = 0, FAULT = 0. The held command is 000, the state is COAST, and all counters are 0.
- Input register: MOTOR_STAT and the clamped DUTY are registered once, adding 1 cycle of latency. A command change is detected when the registered command differs from the held command.
- Prescaler: counts 0 to PRESCALE-1 and pulses step_tick at the wrap. The PWM counter pwm_cnt advances 0 to 99 on step_tick; its wrap is period_end.
- PWM output: asserted when pwm_cnt < CUR_DUTY. CUR_DUTY = 0 gives a constant-low output; CUR_DUTY = 100 gives a constant-high output.
- State COAST: all bridge outputs 00, EN = 0.
- State RUN: wheel directions per command:
  - fwd: L = 10, R = 10.
  - back: L = 01, R = 01.
  - left: L = 01, R = 10.
  - right: L = 10, R = 01.
  - EN = PWM on both wheels.
- State BRAKE: L_IN = R_IN = 11, L_EN = R_EN = 1 (full), CUR_DUTY forced to 0.
- State DEAD: all bridge outputs 00, EN = 0, DEAD = 1.
- Transitions:
  - Any detected change: enter DEAD on the next edge, load dead_cnt = DEAD_CYCLES-1, latch the new command.
  - Further changes during DEAD: only update the latched command; the counter is not restarted.
  - dead_cnt = 0: enter COAST, RUN or BRAKE per the latched command, clear the prescaler and pwm_cnt, and set CUR_DUTY = 0 (ramp enabled) or the target (ramp disabled).
- Invalid command 110/111: treated as brake after dead time, and FAULT is set on the cycle the registered command is invalid.
- Duty update happens only at period_end in RUN, so the PWM never glitches mid-period:
  - Target above CUR_DUTY: CUR_DUTY = min(CUR_DUTY + RAMP_STEP, target).
  - Target at or below CUR_DUTY: CUR_DUTY = target immediately.
- DUTY change alone (command unchanged): no dead time; only the period-boundary update applies.
- Width rule: the ramp add is computed at 8 bits, then clamped to target, so the 7-bit CUR_DUTY never wraps.
- Reset asserted mid-DEAD or mid-period: all outputs take their reset values asynchronously. After release, the block starts in COAST with no dead time.

Optional Feature:
- Macro MOTOR_DRIVE_SOFT_START_EN.
- Defined: ramp-up as described.
- Undefined: CUR_DUTY loads the target directly on entry to RUN and at every period_end; RAMP_STEP is unused.
- Dead-time behaviour is identical in both builds.

Test Plan:
- Sim parameters for all scenarios: PRESCALE = 1, DEAD_CYCLES = 8, RAMP_STEP = 25, ramp defined.
- Reset, then MOTOR_STAT = 001 with DUTY = 60 -> DEAD = 1 for 8 cycles, then L_IN = R_IN = 10. CUR_DUTY steps 0 -> 25 -> 50 -> 60 over successive periods. L_EN is high for 60 of every 100 steps once settled.
- Running fwd at 60, then MOTOR_STAT = 101 -> 8 cycles with all outputs 0, then IN = 01, CUR_DUTY restarts at 0 and ramps.
- Running at 60, then DUTY = 20 with the command unchanged -> no DEAD; CUR_DUTY = 20 at the next period_end, never mid-period.
- DUTY = 120, command 001 -> CUR_DUTY settles at 100 and L_EN is constant high.
- MOTOR_STAT = 111 -> FAULT = 1 and stays set; after dead time, IN = 11 and EN = 1. Then MOTOR_STAT = 000 -> COAST, FAULT still 1.
- Command 001 -> 100 -> 010 within the DEAD window, then RESET_N low at dead_cnt = 3 -> outputs drop to their reset values immediately; after release the block is in COAST.
